rx_serial_paralelo: RTL and testbench



---
 rtl/rx_serial_paralelo.sv | 140 ++++++++++++++
 tb/tb_rx_serial_paralelo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rx_serial_paralelo.sv
// Serial-to-parallel receiver: MSB-first bit stream, comma-based byte alignment,
// lock after LOCK_COUNT consecutive aligned commas, then one byte per DATA_W clocks.
module rx_serial_paralelo #(
   parameter int unsigned          DATA_W     = 8,
   parameter logic [DATA_W-1:0]    COMMA      = 8'hBC,
   parameter int unsigned          LOCK_COUNT = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              byte_strobe,
   output logic              active
);

   localparam int unsigned BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned CCW = $clog2(LOCK_COUNT + 1);

   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
   localparam logic [CCW-1:0] LOCK_C   = CCW'(LOCK_COUNT);
   localparam logic [CCW-1:0] CNT_ONE  = CCW'(1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic [DATA_W-1:0]   sr_q,        sr_d;
   logic [BCW-1:0]      bit_cnt_q,   bit_cnt_d;
   logic [CCW-1:0]      comma_cnt_q, comma_cnt_d;
   logic [DATA_W-1:0]   data_out_q,  data_out_d;
   logic                valid_q,     valid_d;
   logic                strobe_q,    strobe_d;
   logic                active_q,    active_d;

   logic [DATA_W-1:0]   nxt;
   logic                byte_done;
   logic                is_comma;
   logic [BCW-1:0]      bit_cnt_inc;
   logic [CCW-1:0]      comma_cnt_inc;

   always_comb begin
      nxt           = {sr_q[DATA_W-2:0], data_in};
      is_comma      = (nxt == COMMA);
      byte_done     = (bit_cnt_q == BIT_LAST);
      bit_cnt_inc   = byte_done ? '0 : bit_cnt_q + BCW'(1);
      comma_cnt_inc = comma_cnt_q + CNT_ONE;

      sr_d        = nxt;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      comma_cnt_d = comma_cnt_q;
      data_out_d  = data_out_q;
      valid_d     = valid_q;
      strobe_d    = 1'b0;
      active_d    = active_q;

      case (state_q)
         SEARCH: begin
            // Sliding window: any comma match sets the byte boundary here.
            bit_cnt_d = '0;
            if (is_comma) begin
               comma_cnt_d = CNT_ONE;
               if (LOCK_COUNT == 1) begin
                  state_d  = ACTIVE;
                  active_d = 1'b1;
               end else begin
                  state_d = ALIGN;
               end
            end
         end

         ALIGN: begin
            bit_cnt_d = bit_cnt_inc;
            if (byte_done) begin
               if (is_comma) begin
                  if (comma_cnt_q != LOCK_C) begin
                     comma_cnt_d = comma_cnt_inc;
                  end
                  if (comma_cnt_inc == LOCK_C) begin
                     state_d  = ACTIVE;
                     active_d = 1'b1;
                  end
               end else begin
                  // A non-comma on the boundary discards all partial lock progress.
                  state_d     = SEARCH;
                  comma_cnt_d = '0;
                  bit_cnt_d   = '0;
               end
            end
         end

         ACTIVE: begin
            bit_cnt_d = bit_cnt_inc;
            if (byte_done) begin
               data_out_d = nxt;
               valid_d    = !is_comma;
               strobe_d   = 1'b1;
            end
         end

         default: begin
            state_d     = SEARCH;
            bit_cnt_d   = '0;
            comma_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= SEARCH;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         comma_cnt_q <= '0;
         data_out_q  <= '0;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         data_out_q  <= data_out_d;
         valid_q     <= valid_d;
         strobe_q    <= strobe_d;
         active_q    <= active_d;
      end
   end

   assign data_out    = data_out_q;
   assign valid_out   = valid_q;
   assign byte_strobe = strobe_q;
   assign active      = active_q;

endmodule

// File: tb/tb_rx_serial_paralelo.sv
// Directed bench for rx_serial_paralelo: lock, misalignment, broken lock,
// comma while active and asynchronous reset mid-byte.
module tb_rx_serial_paralelo;

   logic       clk;
   logic       reset_L;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;

   int checks   = 0;
   int failures = 0;
   int strobe_cnt = 0;

   rx_serial_paralelo dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      @(posedge clk);
      #1;
      if (byte_strobe) strobe_cnt++;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      data_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;
      strobe_cnt = 0;
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_data"},   int'(data_out),    0);
      check_val({tag, "_valid"},  int'(valid_out),   0);
      check_val({tag, "_strobe"}, int'(byte_strobe), 0);
      check_val({tag, "_active"}, int'(active),      0);
   endtask

   initial begin
      reset_L = 1'b1;
      data_in = 1'b0;
      #2;

      // Basic lock and data
      do_reset();
      check_zero("rst");
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      for (int i = 7; i >= 1; i--) send_bit(1'b0 ^ ((8'hBC >> i) & 1));
      check_val("t1_active_bit31", int'(active), 0);
      send_bit(1'b0);
      check_val("t1_active_bit32", int'(active), 1);
      check_val("t1_no_strobe_lock", strobe_cnt, 0);
      send_byte(8'h12);
      check_val("t1_data_12", int'(data_out), 'h12);
      check_val("t1_valid_12", int'(valid_out), 1);
      check_val("t1_strobe_12", int'(byte_strobe), 1);
      send_bit(1'b1);
      check_val("t1_strobe_pulse", int'(byte_strobe), 0);
      check_val("t1_data_hold", int'(data_out), 'h12);
      for (int i = 6; i >= 0; i--) send_bit(((8'hA5 >> i) & 1) != 0);
      check_val("t1_data_A5", int'(data_out), 'hA5);
      check_val("t1_strobe_count", strobe_cnt, 2);

      // Comma while active
      send_byte(8'hBC);
      check_val("t4_data_BC", int'(data_out), 'hBC);
      check_val("t4_valid_BC", int'(valid_out), 0);
      check_val("t4_strobe_BC", int'(byte_strobe), 1);
      send_byte(8'h07);
      check_val("t4_data_07", int'(data_out), 'h07);
      check_val("t4_valid_07", int'(valid_out), 1);

      // Asynchronous reset at bit 3 of an active byte
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      #2;
      reset_L = 1'b0;
      #1;
      check_zero("t5_async");
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;
      strobe_cnt = 0;
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      check_val("t5_active_3commas", int'(active), 0);
      send_byte(8'hBC);
      check_val("t5_active_4commas", int'(active), 1);
      send_byte(8'hC4);
      check_val("t5_data_C4", int'(data_out), 'hC4);
      check_val("t5_valid_C4", int'(valid_out), 1);

      // Misaligned start
      do_reset();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      for (int i = 7; i >= 1; i--) send_bit(((8'hBC >> i) & 1) != 0);
      check_val("t2_active_early", int'(active), 0);
      send_bit(1'b0);
      check_val("t2_active_lock", int'(active), 1);
      send_byte(8'h5A);
      check_val("t2_data_5A", int'(data_out), 'h5A);
      check_val("t2_strobe_5A", int'(byte_strobe), 1);
      for (int i = 7; i >= 1; i--) send_bit(((8'h81 >> i) & 1) != 0);
      check_val("t2_strobe_gap", strobe_cnt, 1);
      send_bit(1'b1);
      check_val("t2_strobe_period", strobe_cnt, 2);
      check_val("t2_data_81", int'(data_out), 'h81);

      // Broken alignment
      do_reset();
      send_byte(8'hBC);
      send_byte(8'hBC);
      send_byte(8'h00);
      check_val("t3_active_after_00", int'(active), 0);
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      check_val("t3_active_3fresh", int'(active), 0);
      send_byte(8'hBC);
      check_val("t3_active_4fresh", int'(active), 1);
      send_byte(8'h33);
      check_val("t3_data_33", int'(data_out), 'h33);
      check_val("t3_valid_33", int'(valid_out), 1);
      check_val("t3_strobe_count", strobe_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
